// File: rtl/fetch_unit.sv
// Instruction fetch front end: walks the PC, issues one memory request at a
// time and pushes {pc, instr} into the downstream instruction FIFO.
//
// state | meaning
// ------+---------------------------------------------------------------
// REQ   | request valid on imem_req_addr = pc, waiting for imem_req_ready
// WAIT  | one request outstanding, waiting for imem_resp_valid
// HOLD  | fetched entry held in hold_pc/hold_instr, waiting to push
// DROP  | squashed request outstanding; its response will be discarded
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_resp_valid,
    input  logic [XLEN-1:0]   imem_resp_data,
    output logic              fifo_write_en,
    output logic [2*XLEN-1:0] fifo_write_data,
    input  logic              fifo_full,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic [XLEN-1:0] hold_instr_q, hold_instr_d;
    logic [XLEN-1:0] redirect_target;
    logic            req_fire;

    // Low two bits of the redirect address are dropped to keep fetch word-aligned.
    assign redirect_target = redirect_pc & ~XLEN'(3);

    assign imem_req_addr   = pc_q;
    assign fifo_write_data = {hold_pc_q, hold_instr_q};

    // Next-state, datapath updates and handshake outputs; redirect overrides last.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        req_pc_d       = req_pc_q;
        hold_pc_d      = hold_pc_q;
        hold_instr_d   = hold_instr_q;
        imem_req_valid = (state_q == REQ) && !reset;
        fifo_write_en  = (state_q == HOLD) && !fifo_full && !redirect_valid;
        req_fire       = imem_req_valid && imem_req_ready;

        case (state_q)
            REQ: begin
                if (req_fire) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(4);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    hold_pc_d    = req_pc_q;
                    hold_instr_d = imem_resp_data;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (fifo_write_en) begin
                    state_d = REQ;
                end
            end
            DROP: begin
                if (imem_resp_valid) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase

        if (redirect_valid) begin
            pc_d         = redirect_target;
            hold_pc_d    = hold_pc_q;
            hold_instr_d = hold_instr_q;
            case (state_q)
                REQ:     state_d = req_fire ? DROP : REQ;
                WAIT:    state_d = imem_resp_valid ? REQ : DROP;
                HOLD:    state_d = REQ;
                // A response landing in the same cycle retires the squashed
                // request, so there is nothing left to wait for.
                DROP:    state_d = imem_resp_valid ? REQ : DROP;
                default: state_d = REQ;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory model, a
// scoreboard of expected FIFO pushes, and a second instance that checks
// PC wrap-around from a high reset address.
`define CHK(TAG, OBS, EXP) \
    begin \
        n_checks++; \
        assert ((OBS) === (EXP)) n_pass++; \
        else begin \
            n_fail++; \
            $error("FAIL %s: observed %h expected %h", TAG, (OBS), (EXP)); \
        end \
    end

module tb_fetch_unit;

    localparam logic [31:0] PAT = 32'hA5A5_A5A5;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        fifo_write_en;
    logic [63:0] fifo_write_data;
    logic        fifo_full;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        req2_valid;
    logic [31:0] req2_addr;
    logic        req2_ready;
    logic        resp2_valid;
    logic [31:0] resp2_data;
    logic        wen2;
    logic [63:0] wdata2;
    logic        full2;
    logic        redir2_valid;
    logic [31:0] redir2_pc;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;

    logic [63:0] sb[$];
    logic [63:0] exp_push;
    logic [31:0] addr2_q[$];

    int          mem_lat = 1;
    int          mem_cnt = 0;
    logic [31:0] mem_addr;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .fifo_write_en   (fifo_write_en),
        .fifo_write_data (fifo_write_data),
        .fifo_full       (fifo_full),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (req2_valid),
        .imem_req_addr   (req2_addr),
        .imem_req_ready  (req2_ready),
        .imem_resp_valid (resp2_valid),
        .imem_resp_data  (resp2_data),
        .fifo_write_en   (wen2),
        .fifo_write_data (wdata2),
        .fifo_full       (full2),
        .redirect_valid  (redir2_valid),
        .redirect_pc     (redir2_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: response pulse mem_lat cycles after the accepting cycle,
    // instr = addr ^ PAT. Deliberately unaffected by DUT reset.
    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
    end
    always @(posedge clk) begin
        imem_resp_valid <= 1'b0;
        if (imem_req_valid && imem_req_ready) begin
            if (mem_lat <= 1) begin
                imem_resp_valid <= 1'b1;
                imem_resp_data  <= imem_req_addr ^ PAT;
            end else begin
                mem_addr <= imem_req_addr;
                mem_cnt  <= mem_lat - 1;
            end
        end else if (mem_cnt == 1) begin
            imem_resp_valid <= 1'b1;
            imem_resp_data  <= mem_addr ^ PAT;
            mem_cnt         <= 0;
        end else if (mem_cnt > 1) begin
            mem_cnt <= mem_cnt - 1;
        end
    end

    // Free-running single-cycle memory for the wrap-around instance.
    initial begin
        req2_ready   = 1'b1;
        full2        = 1'b0;
        redir2_valid = 1'b0;
        redir2_pc    = '0;
        resp2_valid  = 1'b0;
        resp2_data   = '0;
    end
    always @(posedge clk) begin
        resp2_valid <= req2_valid && req2_ready;
        resp2_data  <= req2_addr;
        if (req2_valid && req2_ready) addr2_q.push_back(req2_addr);
    end

    // Scoreboard: every push must match the oldest expected entry.
    always @(negedge clk) begin
        if (fifo_write_en) begin
            n_checks++;
            assert (sb.size() != 0) n_pass++;
            else begin
                n_fail++;
                $error("FAIL push_unexpected: observed push %h expected none", fifo_write_data);
            end
            if (sb.size() != 0) begin
                exp_push = sb.pop_front();
                `CHK("push_data", fifo_write_data, exp_push)
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        fifo_full      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset for three cycles.
        for (int i = 0; i < 3; i++) begin
            step(1);
            `CHK("rst_req_valid", imem_req_valid, 1'b0)
            `CHK("rst_write_en", fifo_write_en, 1'b0)
            `CHK("rst_write_data", fifo_write_data, 64'h0)
        end

        // Free-running fetch: one push every 3 cycles.
        reset = 1'b0;
        sb.push_back({32'h0, 32'h0 ^ PAT});
        sb.push_back({32'h4, 32'h4 ^ PAT});
        sb.push_back({32'h8, 32'h8 ^ PAT});
        #1;
        for (int i = 0; i < 9; i++) begin
            `CHK("tput_req_valid", imem_req_valid, (i % 3 == 0))
            if (i % 3 == 0) `CHK("tput_req_addr", imem_req_addr, 32'(4 * (i / 3)))
            `CHK("tput_write_en", fifo_write_en, (i % 3 == 2))
            step(1);
        end

        // Back-pressure while holding the entry for pc 0xC.
        fifo_full = 1'b1;
        sb.push_back({32'hC, 32'hC ^ PAT});
        step(2);
        for (int i = 0; i < 10; i++) begin
            `CHK("full_write_en", fifo_write_en, 1'b0)
            `CHK("full_write_data", fifo_write_data, {32'hC, 32'hC ^ PAT})
            `CHK("full_req_valid", imem_req_valid, 1'b0)
            step(1);
        end
        fifo_full = 1'b0;
        #1;
        `CHK("unfull_write_en", fifo_write_en, 1'b1)
        step(1);
        `CHK("after_hold_req_valid", imem_req_valid, 1'b1)
        `CHK("after_hold_req_addr", imem_req_addr, 32'h10)
        `CHK("after_hold_write_en", fifo_write_en, 1'b0)

        // Redirect while waiting; stale response arrives two cycles later.
        mem_lat = 3;
        step(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        #1;
        `CHK("redir_wait_write_en", fifo_write_en, 1'b0)
        step(1);
        redirect_valid = 1'b0;
        #1;
        `CHK("drop_req_valid", imem_req_valid, 1'b0)
        `CHK("drop_pc", imem_req_addr, 32'h100)
        step(2);
        `CHK("post_drop_req_valid", imem_req_valid, 1'b1)
        `CHK("post_drop_req_addr", imem_req_addr, 32'h100)
        mem_lat = 1;
        sb.push_back({32'h100, 32'h100 ^ PAT});
        step(3);
        `CHK("next_req_addr", imem_req_addr, 32'h104)

        // Redirect in HOLD with FIFO not full: the entry for 0x104 is dropped.
        step(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        #1;
        `CHK("redir_hold_write_en", fifo_write_en, 1'b0)
        step(1);
        redirect_valid = 1'b0;
        #1;
        `CHK("redir_hold_req_valid", imem_req_valid, 1'b1)
        `CHK("redir_hold_req_addr", imem_req_addr, 32'h200)
        sb.push_back({32'h200, 32'h200 ^ PAT});
        step(3);
        `CHK("after_redir_req_addr", imem_req_addr, 32'h204)

        // Memory not ready for five cycles: request held stable.
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            `CHK("stall_req_valid", imem_req_valid, 1'b1)
            `CHK("stall_req_addr", imem_req_addr, 32'h204)
            step(1);
        end

        // Reset in the middle of WAIT; the late response must be ignored.
        imem_req_ready = 1'b1;
        mem_lat        = 3;
        step(1);
        `CHK("wait_req_valid", imem_req_valid, 1'b0)
        reset = 1'b1;
        step(1);
        `CHK("mid_rst_req_valid", imem_req_valid, 1'b0)
        reset          = 1'b0;
        imem_req_ready = 1'b0;
        step(1);
        `CHK("stale_resp_req_valid", imem_req_valid, 1'b1)
        `CHK("stale_resp_req_addr", imem_req_addr, 32'h0)
        `CHK("stale_resp_write_en", fifo_write_en, 1'b0)
        step(1);
        `CHK("post_stale_req_valid", imem_req_valid, 1'b1)
        `CHK("post_stale_req_addr", imem_req_addr, 32'h0)
        `CHK("post_stale_write_en", fifo_write_en, 1'b0)
        mem_lat        = 1;
        imem_req_ready = 1'b1;
        sb.push_back({32'h0, 32'h0 ^ PAT});
        step(4);
        `CHK("sb_drained", sb.size(), 0)

        // Wrap-around instance: first three request addresses.
        `CHK("wrap_count", (addr2_q.size() >= 3), 1'b1)
        if (addr2_q.size() >= 3) begin
            `CHK("wrap_addr0", addr2_q[0], 32'hFFFF_FFF8)
            `CHK("wrap_addr1", addr2_q[1], 32'hFFFF_FFFC)
            `CHK("wrap_addr2", addr2_q[2], 32'h0000_0000)
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
